// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the byte-lane extract/merge helpers used by lsu_byte_lane.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        RD_ISSUE = ST_RD_ISSUE,
        RD_WAIT  = ST_RD_WAIT,
        WR_ISSUE = ST_WR_ISSUE,
        RESP     = ST_RESP
    } lsu_state_t;

    // Pick the addressed byte/half out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'b0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the store data onto the addressed lane, keeping the other bytes.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (funct3)
            F3_B: begin
                case (off)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering: extended load value and read-modify-write
// store word for the latched request.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    assign load_value = lane_extract(word, addr_lo, funct3);
    assign store_word = lane_merge(word, addr_lo, funct3, wdata);

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit driving a word-addressed synchronous memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of aligning them.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_load_data,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    lsu_state_t  state;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;

    logic        f3_bad;
    logic        out_of_range;
    logic        req_err;
    logic [1:0]  aligned_off;
    logic [31:0] word_index;
    logic [31:0] load_value;
    logic [31:0] store_word;

    assign req_ready  = (state == IDLE);
    assign word_index = {2'b00, req_addr[31:2]};

    // Classify the incoming request; only meaningful while idle.
    always_comb begin
        f3_bad       = 1'b0;
        aligned_off  = req_addr[1:0];
        out_of_range = (word_index >= DEPTH_W);
        case (req_funct3)
            F3_B:          f3_bad = 1'b0;
            F3_H:          aligned_off[0] = 1'b0;
            F3_W:          aligned_off    = 2'b00;
            F3_BU:         f3_bad = req_we;
            F3_HU: begin
                f3_bad         = req_we;
                aligned_off[0] = 1'b0;
            end
            default:       f3_bad = 1'b1;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = f3_bad || out_of_range || (aligned_off != req_addr[1:0]);
`else
        req_err = f3_bad || out_of_range;
`endif
    end

    lsu_byte_lane u_lane (
        .word       (mem_read_data),
        .addr_lo    (lat_off),
        .funct3     (lat_f3),
        .wdata      (lat_wdata),
        .load_value (load_value),
        .store_word (store_word)
    );

    // Strobes and response pulses default low each cycle; address, write data
    // and load data hold until explicitly reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_we         <= 1'b0;
            lat_f3         <= 3'b0;
            lat_off        <= 2'b0;
            lat_wdata      <= '0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_load_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_f3    <= req_funct3;
                        lat_off   <= aligned_off;
                        lat_wdata <= req_wdata;
                        if (req_err) begin
                            state          <= RESP;
                            resp_valid     <= 1'b1;
                            resp_err       <= 1'b1;
                            resp_load_data <= '0;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            state          <= WR_ISSUE;
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                            mem_address    <= word_index;
                        end else begin
                            state       <= RD_ISSUE;
                            mem_read    <= 1'b1;
                            mem_address <= word_index;
                        end
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (lat_we) begin
                        state          <= WR_ISSUE;
                        mem_write      <= 1'b1;
                        mem_write_data <= store_word;
                    end else begin
                        state          <= RESP;
                        resp_valid     <= 1'b1;
                        resp_load_data <= load_value;
                    end
                end
                WR_ISSUE: begin
                    state          <= RESP;
                    resp_valid     <= 1'b1;
                    resp_load_data <= '0;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed vectors, reset/back-to-back
// sequences and randomized requests against a word-array reference model.
module tb_lsu_mem_port;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_load_data;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    lsu_mem_port #(.DEPTH(1024), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_load_data (resp_load_data),
        .resp_err       (resp_err),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Attached memory: 64 backed words, 1-cycle synchronous read, plus a backdoor load port.
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_val;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        if (mem_write && mem_address < 32'd64) mem[mem_address[5:0]] <= mem_write_data;
        if (mem_read) mem_read_data <= (mem_address < 32'd64) ? mem[mem_address[5:0]] : 32'hBAD0BAD0;
    end

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          resp_cnt = 0;
    logic        overlap = 1'b0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always @(posedge clk) begin
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_address;
            last_wr_data <= mem_write_data;
        end
        if (mem_read && mem_write) overlap <= 1'b1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic backdoor(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_idx = idx;
        bd_val = val;
        bd_we  = 1'b1;
        @(negedge clk);
        bd_we  = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Issue one request and wait (bounded) for its response pulse.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] got_data,
                                 output logic got_err, output int lat, output int nrd, output int nwr);
        int guard;
        int rd0;
        int wr0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) checkOutput("ready_timeout", {31'b0, req_ready}, 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got_data = '0;
        got_err = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat      = k;
                got_data = resp_load_data;
                got_err  = resp_err;
                break;
            end
        end
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        preset;
        logic [5:0]  pidx;
        logic [31:0] pval;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic        chk_word;
        logic [5:0]  widx;
        logic [31:0] exp_word;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] got_data;
    logic        got_err;
    int          lat;
    int          nrd;
    int          nwr;

    // Reference-model scratch
    logic        r_we;
    logic [2:0]  r_f3;
    int unsigned r_idx;
    int unsigned r_off;
    int unsigned r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_misal;
    logic [63:0] r_mask;
    logic [31:0] r_val;
    logic [31:0] r_new;
    int          e_lat;
    int          e_rd;
    int          e_wr;
    int          resp0;
    int          wr0;
    int          rd0;
    int          accepts;
    int          resp_times[$];
    int          g1;
    int          g2;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b0;
        req_addr = '0;
        req_wdata = '0;
        bd_we = 1'b0;
        bd_idx = '0;
        bd_val = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        checkOutput("rst_load_data", resp_load_data, 32'd0);
        checkOutput("rst_mem_address", mem_address, 32'd0);
        checkOutput("rst_mem_wdata", mem_write_data, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) backdoor(i[5:0], 32'h0);

        // we, f3, addr, wdata, preset, pidx, pval, exp_data, exp_err, lat, rd, wr, chk, widx, word
        vecs.push_back('{1'b0, F3_B,  32'h1,    32'h0,        1'b1, 6'd0, 32'h8081F2F3, 32'hFFFFFFF2, 1'b0, 3, 1, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b0, F3_BU, 32'h3,    32'h0,        1'b0, 6'd0, 32'h0,        32'h00000080, 1'b0, 3, 1, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b0, F3_H,  32'h2,    32'h0,        1'b0, 6'd0, 32'h0,        32'hFFFF8081, 1'b0, 3, 1, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b0, F3_HU, 32'h2,    32'h0,        1'b0, 6'd0, 32'h0,        32'h00008081, 1'b0, 3, 1, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b1, F3_W,  32'h10,   32'hDEADBEEF, 1'b0, 6'd0, 32'h0,        32'h0,        1'b0, 2, 0, 1, 1'b1, 6'd4, 32'hDEADBEEF});
        vecs.push_back('{1'b0, F3_W,  32'h10,   32'h0,        1'b0, 6'd0, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b1, F3_B,  32'h12,   32'h123456AB, 1'b1, 6'd4, 32'h11223344, 32'h0,        1'b0, 4, 1, 1, 1'b1, 6'd4, 32'h11AB3344});
        vecs.push_back('{1'b1, F3_H,  32'h10,   32'h5555CAFE, 1'b0, 6'd0, 32'h0,        32'h0,        1'b0, 4, 1, 1, 1'b1, 6'd4, 32'h11ABCAFE});
        vecs.push_back('{1'b0, 3'b011, 32'h0,   32'h0,        1'b0, 6'd0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b0, F3_B,  32'h1000, 32'h0,        1'b0, 6'd0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b1, F3_BU, 32'h8,    32'hFFFFFFFF, 1'b1, 6'd2, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 1'b1, 6'd2, 32'h12345678});
        vecs.push_back('{1'b1, F3_W,  32'h1000, 32'h0,        1'b0, 6'd0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 6'd0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, F3_H,  32'h1,    32'h0,        1'b0, 6'd0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b0, F3_W,  32'h3,    32'h0,        1'b0, 6'd0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 6'd0, 32'h0});
`else
        vecs.push_back('{1'b0, F3_H,  32'h1,    32'h0,        1'b0, 6'd0, 32'h0,        32'hFFFFF2F3, 1'b0, 3, 1, 0, 1'b0, 6'd0, 32'h0});
        vecs.push_back('{1'b0, F3_W,  32'h3,    32'h0,        1'b0, 6'd0, 32'h0,        32'h8081F2F3, 1'b0, 3, 1, 0, 1'b0, 6'd0, 32'h0});
`endif

        foreach (vecs[i]) begin
            if (vecs[i].preset) backdoor(vecs[i].pidx, vecs[i].pval);
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, got_data, got_err, lat, nrd, nwr);
            checkOutput($sformatf("v%0d_data", i), got_data, vecs[i].exp_data);
            checkOutput($sformatf("v%0d_err", i), {31'b0, got_err}, {31'b0, vecs[i].exp_err});
            checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("v%0d_reads", i), nrd, vecs[i].exp_rd);
            checkOutput($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wr);
            if (vecs[i].chk_word)
                checkOutput($sformatf("v%0d_mem_word", i), mem[vecs[i].widx], vecs[i].exp_word);
            if (vecs[i].exp_wr != 0) begin
                checkOutput($sformatf("v%0d_wr_addr", i), last_wr_addr, {26'b0, vecs[i].widx});
                checkOutput($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].exp_word);
            end
        end

        // Reset while an SB sits in RD_WAIT: the merge write must never happen.
        backdoor(6'd8, 32'h55667788);
        wr0 = wr_cnt;
        resp0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h21; req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_rd_issue", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_write_low", {31'b0, mem_write}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_ready", {31'b0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("rstmid_writes", wr_cnt - wr0, 32'd0);
        checkOutput("rstmid_resps", resp_cnt - resp0, 32'd0);
        checkOutput("rstmid_mem_word", mem[8], 32'h55667788);

        // req_valid held high for three loads: accepted only when idle.
        backdoor(6'd5, 32'h0BADF00D);
        rd0 = rd_cnt;
        accepts = 0;
        resp_times.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h14;
        for (int c = 0; c < 20; c++) begin
            if (req_valid && req_ready) accepts++;
            if (resp_valid) begin
                resp_times.push_back(c);
                checkOutput($sformatf("b2b_data%0d", resp_times.size()), resp_load_data, 32'h0BADF00D);
            end
            if (accepts == 3 && !req_ready) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        g1 = (resp_times.size() >= 2) ? resp_times[1] - resp_times[0] : -1;
        g2 = (resp_times.size() >= 3) ? resp_times[2] - resp_times[1] : -1;
        checkOutput("b2b_resp_count", resp_times.size(), 32'd3);
        checkOutput("b2b_accepts", accepts, 32'd3);
        checkOutput("b2b_first_latency", (resp_times.size() >= 1) ? resp_times[0] : -1, 32'd3);
        checkOutput("b2b_gap1", g1, 32'd4);
        checkOutput("b2b_gap2", g2, 32'd4);
        checkOutput("b2b_reads", rd_cnt - rd0, 32'd3);

        // Randomized requests against the reference word array.
        for (int i = 0; i < 64; i++) backdoor(i[5:0], $urandom);
        for (int n = 0; n < 80; n++) begin
            r_we    = 1'($urandom % 2);
            r_f3    = 3'($urandom % 8);
            r_idx   = ($urandom % 8 == 0) ? 1024 + $urandom % 1024 : $urandom % 64;
            r_off   = $urandom % 4;
            r_addr  = (r_idx << 2) | r_off;
            r_wdata = $urandom;
            r_size  = (r_f3[1:0] == 2'd0) ? 1 : (r_f3[1:0] == 2'd1) ? 2 : 4;
            r_err   = (r_f3 == 3'd3) || (r_f3 == 3'd6) || (r_f3 == 3'd7) || (r_we && r_f3 >= 3'd4) || (r_idx >= 1024);
            r_misal = (r_off % r_size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_err = r_err || r_misal;
`else
            r_off = r_off - (r_off % r_size);
`endif
            r_val = 32'h0;
            r_new = 32'h0;
            e_rd  = 0;
            e_wr  = 0;
            r_mask = (64'd1 << (8 * r_size)) - 64'd1;
            if (r_err) begin
                e_lat = 1;
            end else if (!r_we) begin
                e_lat = 3;
                e_rd  = 1;
                r_val = 32'((64'(ref_mem[r_idx]) >> (8 * r_off)) & r_mask);
                if (r_f3 < 3'd4 && r_size < 4 && r_val >= 32'(r_mask >> 1) + 32'd1)
                    r_val = r_val | ~32'(r_mask);
            end else if (r_size == 4) begin
                e_lat = 2;
                e_wr  = 1;
                r_new = r_wdata;
            end else begin
                e_lat = 4;
                e_rd  = 1;
                e_wr  = 1;
                r_new = (ref_mem[r_idx] & ~32'(r_mask << (8 * r_off)))
                      | (32'((64'(r_wdata) & r_mask) << (8 * r_off)));
            end
            applyStimulus(r_we, r_f3, r_addr, r_wdata, got_data, got_err, lat, nrd, nwr);
            checkOutput($sformatf("rnd%0d_err", n), {31'b0, got_err}, {31'b0, r_err});
            checkOutput($sformatf("rnd%0d_latency", n), lat, e_lat);
            checkOutput($sformatf("rnd%0d_data", n), got_data, r_val);
            checkOutput($sformatf("rnd%0d_reads", n), nrd, e_rd);
            checkOutput($sformatf("rnd%0d_writes", n), nwr, e_wr);
            if (e_wr != 0) begin
                ref_mem[r_idx] = r_new;
                checkOutput($sformatf("rnd%0d_mem_word", n), mem[r_idx], r_new);
                checkOutput($sformatf("rnd%0d_wr_addr", n), last_wr_addr, r_idx);
            end
        end

        checkOutput("strobe_overlap", {31'b0, overlap}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
